cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor_pkg.sv | 16 +
 rtl/cacheline_adaptor.sv | 149 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared widths and FSM encoding for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

    localparam int unsigned CL_LINE_W  = 256;
    localparam int unsigned CL_BURST_W = 64;
    localparam int unsigned CL_BEATS   = CL_LINE_W / CL_BURST_W;
    localparam int unsigned CL_ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts whole-line read/write requests into LINE_W/BURST_W beat bursts on the
// memory bus, assembling read beats into a line and slicing write lines into beats.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int unsigned LINE_W  = CL_LINE_W,
    parameter int unsigned BURST_W = CL_BURST_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [CL_ADDR_W-1:0] pmem_address,
    input  logic [LINE_W-1:0]    pmem_wdata,
    output logic [LINE_W-1:0]    pmem_rdata,
    output logic                 pmem_resp,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [CL_ADDR_W-1:0] mem_address,
    output logic [BURST_W-1:0]   mem_wdata,
    input  logic [BURST_W-1:0]   mem_rdata,
    input  logic                 mem_resp
);

    localparam int unsigned BEATS      = LINE_W / BURST_W;
    localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LINE_BYTES = LINE_W / 8;
    localparam logic [CL_ADDR_W-1:0] ADDR_MASK = ~(CL_ADDR_W'(LINE_BYTES) - CL_ADDR_W'(1));
    localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CL_ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]      wline_q, wline_d;
    logic [LINE_W-1:0]      rdata_q, rdata_d;
    logic [BURST_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic                   pmem_resp_q, pmem_resp_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wline_d     = wline_q;
        rdata_d     = rdata_q;
        mem_wdata_d = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        pmem_resp_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Read has priority; a concurrent write stays pending for the next IDLE.
                if (pmem_read) begin
                    addr_d  = pmem_address & ADDR_MASK;
                    state_d = READ;
                end else if (pmem_write) begin
                    addr_d  = pmem_address & ADDR_MASK;
                    wline_d = pmem_wdata;
                    state_d = WRITE;
                end
            end
            READ: begin
                if (mem_resp) begin
                    for (int unsigned b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            rdata_d[b*BURST_W +: BURST_W] = mem_rdata;
                        end
                    end
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
            end
            WRITE: begin
                if (mem_resp) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (state_d == READ) begin
            mem_read_d = 1'b1;
        end
        if (state_d == WRITE) begin
            mem_write_d = 1'b1;
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (cnt_d == CNT_W'(b)) begin
                    mem_wdata_d = wline_d[b*BURST_W +: BURST_W];
                end
            end
        end
        if (state_d == DONE) begin
            pmem_resp_d = 1'b1;
        end
    end

    // State and datapath registers; reset clears everything, abandoning any burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wline_q     <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            pmem_resp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wline_q     <= wline_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            pmem_resp_q <= pmem_resp_d;
        end
    end

    assign pmem_rdata  = rdata_q;
    assign pmem_resp   = pmem_resp_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed table, corner sequences, random bursts.
module tb_cacheline_adaptor;

    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;

    typedef logic [3:0][63:0] beats_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [255:0] line;
        beats_t      beats;
        logic [31:0] pat;
        int          plen;
        logic [31:0] exp_addr;
        int          exp_resp;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               pmem_read = 1'b0;
    logic               pmem_write = 1'b0;
    logic [31:0]        pmem_address = '0;
    logic [LINE_W-1:0]  pmem_wdata = '0;
    logic [LINE_W-1:0]  pmem_rdata;
    logic               pmem_resp;
    logic               mem_read;
    logic               mem_write;
    logic [31:0]        mem_address;
    logic [BURST_W-1:0] mem_wdata;
    logic [BURST_W-1:0] mem_rdata = '0;
    logic               mem_resp = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [255:0] last_line = '0;

    cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=still running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int id, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s id=%0d got=%h want=%h", nm, id, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Services one burst like a memory would; the request cycle counts as cycle 1.
    // beats = data returned (read) or mem_wdata expected (write); line = expected pmem_rdata (read).
    task automatic do_burst(input bit is_wr, input logic [31:0] exp_addr, input logic [255:0] line,
                            input beats_t beats, input logic [31:0] pat, input int plen,
                            input int exp_resp, input int id);
        int n;
        int p;
        int beat;
        bit done;
        bit r;
        n = 1; p = 0; beat = 0; done = 1'b0;
        while (!done && n < 64) begin
            tick();
            n++;
            if (pmem_resp) begin
                chk("resp_cycle", id, 256'(n), 256'(exp_resp));
                chk("beat_count", id, 256'(beat), 256'(4));
                chk("done_flags", id, 256'({mem_read, mem_write}), 256'(2'b00));
                if (!is_wr) begin
                    chk("rdata", id, pmem_rdata, line);
                    last_line = line;
                end else begin
                    chk("rdata_hold", id, pmem_rdata, last_line);
                    pmem_write = 1'b0;
                end
                if (!is_wr) pmem_read = 1'b0;
                mem_resp = 1'b0;
                done = 1'b1;
            end else begin
                chk("mem_address", id, 256'(mem_address), 256'(exp_addr));
                chk("rw_flags", id, 256'({mem_read, mem_write}), 256'({~is_wr, is_wr}));
                if (is_wr && beat < 4) begin
                    chk("mem_wdata", id, 256'(mem_wdata), 256'(beats[beat[1:0]]));
                    chk("rdata_hold", id, pmem_rdata, last_line);
                end
                pmem_address = $urandom;
                pmem_wdata   = rand256();
                r = 1'b0;
                if (beat < 4) r = (p < plen) ? pat[p] : 1'b1;
                p++;
                mem_resp  = r;
                mem_rdata = {$urandom, $urandom};
                if (r) begin
                    if (!is_wr) mem_rdata = beats[beat[1:0]];
                    beat++;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout id=%0d got=no pmem_resp want=pmem_resp", id);
            pmem_read = 1'b0; pmem_write = 1'b0; mem_resp = 1'b0;
        end
    endtask

    initial begin
        vec_t vt[4];
        beats_t bt;
        beats_t bt2;
        logic [255:0] wl;
        bit wr;
        logic [31:0] a;
        logic [31:0] pat;
        int plen;
        int g;

        vt[0] = '{1'b0, 32'h0000_1234,
                  {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111},
                  {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111},
                  32'h0000_000F, 4, 32'h0000_1220, 6};
        vt[1] = '{1'b1, 32'h0000_0080,
                  {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA},
                  {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA},
                  32'h0000_000F, 4, 32'h0000_0080, 6};
        vt[2] = '{1'b0, 32'hDEAD_BEEF,
                  {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hA5A5A5A55A5A5A5A, 64'h0F0F0F0FF0F0F0F0},
                  {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hA5A5A5A55A5A5A5A, 64'h0F0F0F0FF0F0F0F0},
                  32'h0000_0059, 7, 32'hDEAD_BEE0, 9};
        vt[3] = '{1'b1, 32'hFFFF_FFFF,
                  {64'h8000000000000001, 64'h7FFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000},
                  {64'h8000000000000001, 64'h7FFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000},
                  32'h0000_0055, 7, 32'hFFFF_FFE0, 9};

        // Reset values
        repeat (3) tick();
        chk("rst_rdata", 0, pmem_rdata, 256'(0));
        chk("rst_addr", 0, 256'(mem_address), 256'(0));
        chk("rst_wdata", 0, 256'(mem_wdata), 256'(0));
        chk("rst_flags", 0, 256'({pmem_resp, mem_read, mem_write}), 256'(3'b000));
        reset_n = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 4; i++) begin
            pmem_address = vt[i].addr;
            pmem_wdata   = vt[i].is_wr ? vt[i].line : rand256();
            if (vt[i].is_wr) pmem_write = 1'b1;
            else             pmem_read  = 1'b1;
            do_burst(vt[i].is_wr, vt[i].exp_addr, vt[i].line, vt[i].beats, vt[i].pat,
                     vt[i].plen, vt[i].exp_resp, i);
            tick();
            chk("resp_once", i, 256'({pmem_resp, mem_read, mem_write}), 256'(3'b000));
        end

        // Simultaneous read and write: read first, then the pending write
        wl = rand256();
        bt = rand256();
        pmem_address = 32'h0000_4567;
        pmem_wdata   = wl;
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        do_burst(1'b0, 32'h0000_4560, bt, bt, 32'hF, 4, 6, 100);
        pmem_address = 32'h0000_4567;
        pmem_wdata   = wl;
        tick();
        chk("both_gap", 100, 256'({pmem_resp, mem_read, mem_write}), 256'(3'b000));
        do_burst(1'b1, 32'h0000_4560, wl, wl, 32'hF, 4, 6, 101);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("both_no_third", 102, 256'({pmem_resp, mem_read, mem_write}), 256'(3'b000));
        end

        // mem_resp noise while idle
        for (int c = 0; c < 6; c++) begin
            mem_resp  = ~c[0];
            mem_rdata = {$urandom, $urandom};
            tick();
            chk("idle_noise", 300, 256'({pmem_resp, mem_read, mem_write}), 256'(3'b000));
            chk("idle_rdata", 300, pmem_rdata, last_line);
        end
        mem_resp = 1'b0;
        bt = rand256();
        pmem_address = 32'h0000_0A40;
        pmem_read = 1'b1;
        do_burst(1'b0, 32'h0000_0A40, bt, bt, 32'hF, 4, 6, 301);
        tick();

        // Reset after three read beats
        bt = rand256();
        pmem_address = 32'h0000_2000;
        pmem_read = 1'b1;
        tick();
        for (int b = 0; b < 3; b++) begin
            mem_resp  = 1'b1;
            mem_rdata = bt[b[1:0]];
            tick();
        end
        mem_rdata = {$urandom, $urandom};
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rdata", 200, pmem_rdata, 256'(0));
        chk("mid_rst_addr", 200, 256'(mem_address), 256'(0));
        chk("mid_rst_wdata", 200, 256'(mem_wdata), 256'(0));
        chk("mid_rst_flags", 200, 256'({pmem_resp, mem_read, mem_write}), 256'(3'b000));
        pmem_read = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("mid_rst_noresp", 200, 256'(pmem_resp), 256'(0));
        end
        reset_n = 1'b1;
        mem_resp = 1'b0;
        last_line = '0;
        tick();
        chk("post_rst_idle", 200, 256'({pmem_resp, mem_read, mem_write}), 256'(3'b000));
        chk("post_rst_rdata", 200, pmem_rdata, 256'(0));
        bt2 = rand256();
        pmem_address = 32'h0000_3000;
        pmem_read = 1'b1;
        do_burst(1'b0, 32'h0000_3000, bt2, bt2, 32'hF, 4, 6, 201);
        tick();

        // Random transactions with random beat gaps
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            wl = rand256();
            bt = rand256();
            pat = '0;
            plen = 0;
            for (int b = 0; b < 4; b++) begin
                g = int'($urandom_range(0, 3));
                plen += g;
                pat[plen] = 1'b1;
                plen++;
            end
            pmem_address = a;
            if (wr) begin
                pmem_wdata = wl;
                pmem_write = 1'b1;
                // Request cycle + one cycle per pattern slot + the response cycle.
                do_burst(1'b1, a & 32'hFFFF_FFE0, wl, wl, pat, plen, plen + 2, 1000 + t);
            end else begin
                pmem_wdata = rand256();
                pmem_read  = 1'b1;
                do_burst(1'b0, a & 32'hFFFF_FFE0, bt, bt, pat, plen, plen + 2, 1000 + t);
            end
            g = int'($urandom_range(1, 3));
            for (int c = 0; c < g; c++) begin
                mem_resp = 1'($urandom_range(0, 1));
                tick();
                chk("rand_idle", 1000 + t, 256'({pmem_resp, mem_read, mem_write}), 256'(3'b000));
            end
            mem_resp = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
